// File: rtl/mem_stage_dmem_ctrl.sv
// MEM-stage data-memory controller: byte/word loads and stores on an internal
// byte-addressed RAM with fixed access latency, upstream stall and registered write-back.
module mem_stage_dmem_ctrl #(
  parameter int ADDR_W = 8,
  parameter int LAT    = 2
) (
  input  logic        CLK,
  input  logic        CLR,
  input  logic        enable_i,
  input  logic        rw_i,
  input  logic        size_i,
  input  logic        load_i,
  input  logic        rf_i,
  input  logic [31:0] addr_i,
  input  logic [31:0] wdata_i,
  input  logic [31:0] alu_i,
  output logic        stall_o,
  output logic        rf_o,
  output logic [31:0] wb_data_o
);

  typedef enum logic [1:0] {IDLE = 2'd0, BUSY = 2'd1, DONE = 2'd2} state_t;

  state_t              r_state;
  state_t              w_next;
  logic [3:0]          r_cnt;
  logic [ADDR_W-1:0]   r_addr;
  logic [31:0]         r_wdata;
  logic                r_rw;
  logic                r_size;
  logic                r_load;
  logic                r_rf;
  logic                r_rf_o;
  logic [31:0]         r_wb;
  logic [7:0]          r_mem [2**ADDR_W];

  logic                w_access;
  logic                w_we;
  logic [ADDR_W-1:0]   w_base;
  logic [31:0]         w_rdata;
  logic                w_unused_addr;

  assign w_unused_addr = ^addr_i[31:ADDR_W];

  // State register
  always_ff @(posedge CLK or negedge CLR) begin
    if (!CLR) r_state <= IDLE;
    else      r_state <= w_next;
  end

  // Next-state logic
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (enable_i)     w_next = BUSY;
      BUSY:    if (r_cnt == 4'd0) w_next = DONE;
      DONE:    w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  // Output logic; stall is forced low while reset is held
  always_comb begin
    stall_o = 1'b0;
    if (CLR) begin
      case (r_state)
        IDLE:    stall_o = enable_i;
        BUSY:    stall_o = 1'b1;
        default: stall_o = 1'b0;
      endcase
    end
  end

  assign w_access = (r_state == BUSY) && (r_cnt == 4'd0);
  assign w_we     = w_access && r_rw;
  assign w_base   = {r_addr[ADDR_W-1:2], 2'b00};

  always_comb begin
    if (r_size) w_rdata = {24'd0, r_mem[r_addr]};
    else        w_rdata = {r_mem[{r_addr[ADDR_W-1:2], 2'b11}],
                           r_mem[{r_addr[ADDR_W-1:2], 2'b10}],
                           r_mem[{r_addr[ADDR_W-1:2], 2'b01}],
                           r_mem[w_base]};
  end

  // Request capture, wait counter and write-back registers
  always_ff @(posedge CLK or negedge CLR) begin
    if (!CLR) begin
      r_cnt   <= 4'd0;
      r_addr  <= '0;
      r_wdata <= 32'd0;
      r_rw    <= 1'b0;
      r_size  <= 1'b0;
      r_load  <= 1'b0;
      r_rf    <= 1'b0;
      r_rf_o  <= 1'b0;
      r_wb    <= 32'd0;
    end else begin
      case (r_state)
        IDLE: begin
          if (enable_i) begin
            r_cnt   <= 4'(LAT - 1);
            r_addr  <= addr_i[ADDR_W-1:0];
            r_wdata <= wdata_i;
            r_rw    <= rw_i;
            r_size  <= size_i;
            r_load  <= load_i;
            r_rf    <= rf_i;
            r_rf_o  <= 1'b0;
          end else begin
            r_wb    <= alu_i;
            r_rf_o  <= rf_i;
          end
        end
        BUSY: begin
          if (r_cnt != 4'd0) begin
            r_cnt  <= r_cnt - 4'd1;
            r_rf_o <= 1'b0;
          end else if (!r_rw) begin
            r_wb   <= w_rdata;
            r_rf_o <= r_load & r_rf;
          end else begin
            r_rf_o <= 1'b0;
          end
        end
        default: r_rf_o <= 1'b0;
      endcase
    end
  end

  // RAM is never cleared; a write only fires on the BUSY->DONE edge
  always_ff @(posedge CLK) begin
    if (w_we) begin
      if (r_size) begin
        r_mem[r_addr] <= r_wdata[7:0];
      end else begin
        r_mem[w_base]                           <= r_wdata[7:0];
        r_mem[{r_addr[ADDR_W-1:2], 2'b01}]      <= r_wdata[15:8];
        r_mem[{r_addr[ADDR_W-1:2], 2'b10}]      <= r_wdata[23:16];
        r_mem[{r_addr[ADDR_W-1:2], 2'b11}]      <= r_wdata[31:24];
      end
    end
  end

  assign rf_o      = r_rf_o;
  assign wb_data_o = r_wb;

endmodule

// File: tb/tb_mem_stage_dmem_ctrl.sv
// Directed self-checking bench for mem_stage_dmem_ctrl (LAT=2, ADDR_W=8).
module tb_mem_stage_dmem_ctrl;

  logic        CLK;
  logic        CLR;
  logic        enable_i;
  logic        rw_i;
  logic        size_i;
  logic        load_i;
  logic        rf_i;
  logic [31:0] addr_i;
  logic [31:0] wdata_i;
  logic [31:0] alu_i;
  logic        stall_o;
  logic        rf_o;
  logic [31:0] wb_data_o;

  int tests_run = 0;
  int fails     = 0;

  mem_stage_dmem_ctrl #(.ADDR_W(8), .LAT(2)) dut (
    .CLK(CLK), .CLR(CLR), .enable_i(enable_i), .rw_i(rw_i), .size_i(size_i),
    .load_i(load_i), .rf_i(rf_i), .addr_i(addr_i), .wdata_i(wdata_i),
    .alu_i(alu_i), .stall_o(stall_o), .rf_o(rf_o), .wb_data_o(wb_data_o)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  task automatic idle_inputs();
    enable_i = 1'b0; rw_i = 1'b0; size_i = 1'b0; load_i = 1'b0; rf_i = 1'b0;
    addr_i = 32'd0; wdata_i = 32'd0; alu_i = 32'd0;
  endtask

  // Issue one request from IDLE (called at posedge+1); returns stall count,
  // any rf_o seen while stalled, and the DONE-cycle outputs.
  task automatic mem_op(input logic rw, input logic sz, input logic ld, input logic rf,
                        input logic [31:0] addr, input logic [31:0] wdata,
                        output int n_stall, output logic rf_stalled,
                        output logic [31:0] wb, output logic rf_done, output logic tmo);
    enable_i = 1'b1; rw_i = rw; size_i = sz; load_i = ld; rf_i = rf;
    addr_i = addr; wdata_i = wdata;
    n_stall = 0; rf_stalled = 1'b0; tmo = 1'b1;
    for (int i = 0; i < 20; i++) begin
      #3;
      if (!stall_o) begin
        tmo = 1'b0;
        break;
      end
      n_stall++;
      rf_stalled = rf_stalled | rf_o;
      @(posedge CLK); #1;
    end
    wb = wb_data_o;
    rf_done = rf_o;
    idle_inputs();
    @(posedge CLK); #1;
  endtask

  task automatic test_reset();
    idle_inputs();
    CLR = 1'b0;
    enable_i = 1'b1;
    #3;
    tests_run++;
    if (stall_o !== 1'b0) begin fails++; $display("FAIL reset_stall: got %b want 0", stall_o); end
    tests_run++;
    if (rf_o !== 1'b0) begin fails++; $display("FAIL reset_rf: got %b want 0", rf_o); end
    tests_run++;
    if (wb_data_o !== 32'd0) begin fails++; $display("FAIL reset_wb: got %h want 00000000", wb_data_o); end
    enable_i = 1'b0; alu_i = 32'h55; rf_i = 1'b1;
    @(posedge CLK); #1;
    tests_run++;
    if (wb_data_o !== 32'd0 || rf_o !== 1'b0) begin
      fails++; $display("FAIL reset_hold: got wb=%h rf=%b want 00000000/0", wb_data_o, rf_o);
    end
    @(posedge CLK); #1;
    CLR = 1'b1;
    idle_inputs();
    @(posedge CLK); #1;
  endtask

  task automatic test_word_store_load();
    int n; logic rs, rd, t; logic [31:0] wb;
    mem_op(1'b1, 1'b0, 1'b0, 1'b0, 32'h10, 32'hDEADBEEF, n, rs, wb, rd, t);
    tests_run++;
    if (t || n != 3) begin fails++; $display("FAIL store_stall_cycles: got %0d (tmo=%b) want 3", n, t); end
    tests_run++;
    if (rs !== 1'b0 || rd !== 1'b0) begin fails++; $display("FAIL store_rf: got %b/%b want 0/0", rs, rd); end
    mem_op(1'b0, 1'b0, 1'b1, 1'b1, 32'h10, 32'h0, n, rs, wb, rd, t);
    tests_run++;
    if (t || n != 3) begin fails++; $display("FAIL load_stall_cycles: got %0d (tmo=%b) want 3", n, t); end
    tests_run++;
    if (wb !== 32'hDEADBEEF) begin fails++; $display("FAIL word_load_data: got %h want deadbeef", wb); end
    tests_run++;
    if (rd !== 1'b1 || rs !== 1'b0) begin fails++; $display("FAIL word_load_rf: got done=%b stalled=%b want 1/0", rd, rs); end
  endtask

  task automatic test_byte_load();
    int n; logic rs, rd, t; logic [31:0] wb;
    mem_op(1'b0, 1'b1, 1'b1, 1'b1, 32'h11, 32'h0, n, rs, wb, rd, t);
    tests_run++;
    if (t || wb !== 32'h000000BE) begin fails++; $display("FAIL byte_load_11: got %h want 000000be", wb); end
    mem_op(1'b0, 1'b1, 1'b1, 1'b1, 32'h113, 32'h0, n, rs, wb, rd, t);
    tests_run++;
    if (t || wb !== 32'h000000DE || rd !== 1'b1) begin
      fails++; $display("FAIL byte_load_wrap: got %h rf=%b want 000000de rf=1", wb, rd);
    end
  endtask

  task automatic test_byte_store();
    int n; logic rs, rd, t; logic [31:0] wb;
    mem_op(1'b1, 1'b1, 1'b0, 1'b1, 32'h12, 32'h12345655, n, rs, wb, rd, t);
    tests_run++;
    if (t || wb !== 32'h000000DE || rd !== 1'b0) begin
      fails++; $display("FAIL store_holds_wb: got %h rf=%b want 000000de rf=0", wb, rd);
    end
    mem_op(1'b0, 1'b0, 1'b1, 1'b1, 32'h13, 32'h0, n, rs, wb, rd, t);
    tests_run++;
    if (t || wb !== 32'hDE55BEEF) begin fails++; $display("FAIL word_load_aligned: got %h want de55beef", wb); end
    mem_op(1'b0, 1'b1, 1'b0, 1'b1, 32'h12, 32'h0, n, rs, wb, rd, t);
    tests_run++;
    if (t || wb !== 32'h00000055 || rd !== 1'b0) begin
      fails++; $display("FAIL read_no_load_rf: got %h rf=%b want 00000055 rf=0", wb, rd);
    end
  endtask

  task automatic test_passthrough();
    logic [31:0] vals [4];
    logic        rfs  [4];
    logic        st;
    vals[0] = 32'hCAFE0001; vals[1] = 32'h12345678; vals[2] = 32'h0; vals[3] = 32'hFFFFFFFF;
    rfs[0] = 1'b1; rfs[1] = 1'b0; rfs[2] = 1'b1; rfs[3] = 1'b1;
    st = 1'b0;
    for (int i = 0; i < 4; i++) begin
      enable_i = 1'b0; alu_i = vals[i]; rf_i = rfs[i];
      #3; st = st | stall_o;
      @(posedge CLK); #1;
      tests_run++;
      if (wb_data_o !== vals[i] || rf_o !== rfs[i]) begin
        fails++; $display("FAIL passthrough_%0d: got %h/%b want %h/%b", i, wb_data_o, rf_o, vals[i], rfs[i]);
      end
    end
    tests_run++;
    if (st !== 1'b0) begin fails++; $display("FAIL passthrough_stall: got %b want 0", st); end
    idle_inputs();
    @(posedge CLK); #1;
  endtask

  task automatic test_reset_midop();
    int n; logic rs, rd, t; logic [31:0] wb;
    mem_op(1'b1, 1'b0, 1'b0, 1'b0, 32'h20, 32'hAAAAAAAA, n, rs, wb, rd, t);
    enable_i = 1'b1; rw_i = 1'b1; size_i = 1'b0; addr_i = 32'h20; wdata_i = 32'h11111111;
    @(posedge CLK); #1;
    enable_i = 1'b0;
    #2 CLR = 1'b0;
    #1;
    tests_run++;
    if (stall_o !== 1'b0 || rf_o !== 1'b0 || wb_data_o !== 32'd0) begin
      fails++; $display("FAIL midop_reset_outputs: got stall=%b rf=%b wb=%h want 0/0/00000000", stall_o, rf_o, wb_data_o);
    end
    @(posedge CLK); @(posedge CLK); #1;
    CLR = 1'b1;
    idle_inputs();
    @(posedge CLK); #1;
    mem_op(1'b0, 1'b0, 1'b1, 1'b1, 32'h20, 32'h0, n, rs, wb, rd, t);
    tests_run++;
    if (t || wb !== 32'hAAAAAAAA) begin fails++; $display("FAIL midop_write_abandoned: got %h want aaaaaaaa", wb); end
  endtask

  task automatic test_back_to_back();
    logic [7:0] st_pat;
    logic [7:0] rf_pat;
    enable_i = 1'b1; rw_i = 1'b0; size_i = 1'b0; load_i = 1'b1; rf_i = 1'b1;
    addr_i = 32'h10;
    for (int i = 0; i < 8; i++) begin
      #3;
      st_pat[7-i] = stall_o;
      rf_pat[7-i] = rf_o;
      @(posedge CLK); #1;
    end
    idle_inputs();
    tests_run++;
    if (st_pat !== 8'b1110_1110) begin fails++; $display("FAIL held_stall_pattern: got %b want 11101110", st_pat); end
    tests_run++;
    if (rf_pat !== 8'b0001_0001) begin fails++; $display("FAIL held_rf_pattern: got %b want 00010001", rf_pat); end
    repeat (4) @(posedge CLK);
    #1;
  endtask

  initial begin
    test_reset();
    test_word_store_load();
    test_byte_load();
    test_byte_store();
    test_passthrough();
    test_reset_midop();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", tests_run, fails);
    $finish;
  end

endmodule

// File: doc/mem_stage_dmem_ctrl.md
Name: mem_stage_dmem_ctrl

Overview:
- MEM-stage data-memory controller. It sits directly downstream of the EX/MEM pipeline register and consumes its size/enable/rw/load/rf controls plus the EX-stage address and store data.
- It performs byte or word loads and stores on an internal byte-addressed RAM with a fixed multi-cycle access latency.
- It asserts a stall to freeze upstream stages during an access.
- It drives registered write-back data and register-file write enable to the MEM/WB stage.

Parameters:
- ADDR_W, 8, byte-address width of the internal RAM (2**ADDR_W bytes).
- LAT, 2, number of wait cycles per memory access (legal range 1..15).

Ports:
- CLK  input  1  clock, rising edge.
- CLR  input  1  asynchronous active-low reset.
- enable_i  input  1  memory access request (from EX/MEM).
- rw_i  input  1  0 = read, 1 = write.
- size_i  input  1  0 = word (32-bit), 1 = byte.
- load_i  input  1  result of a read is written to the register file.
- rf_i  input  1  register-file write enable for the instruction.
- addr_i  input  32  byte address (ALU result).
- wdata_i  input  32  store data.
- alu_i  input  32  ALU result for non-memory instructions.
- stall_o  output  1  hold all upstream pipeline registers.
- rf_o  output  1  register-file write enable to MEM/WB.
- wb_data_o  output  32  write-back data to MEM/WB.

Behaviour:
- Reset (CLR=0, asynchronous): FSM goes to IDLE, wait counter=0, rf_o=0, wb_data_o=0. stall_o=0 while CLR=0. RAM contents are not cleared.
- FSM states are IDLE, BUSY and DONE.
- IDLE, enable_i=0 (pass-through):
  - at the next edge, wb_data_o<=alu_i and rf_o<=rf_i;
  - 1-cycle latency; stall_o=0.
- IDLE, enable_i=1:
  - stall_o=1 combinationally in the same cycle;
  - at the edge, capture addr_i[ADDR_W-1:0], wdata_i, rw_i, size_i, load_i and rf_i;
  - load counter with LAT-1; go to BUSY;
  - rf_o<=0 (bubble).
- BUSY:
  - stall_o=1; rf_o holds 0.
  - Counter !=0: decrement.
  - Counter ==0: perform the access at this edge, then go to DONE.
- DONE:
  - stall_o=0; outputs are valid for exactly this cycle;
  - at the edge go to IDLE unconditionally; rf_o<=0 and wb_data_o holds.
  - enable_i seen during DONE still belongs to the completed request and is ignored. Upstream advances on this edge.
- Timing for a request presented in cycle 0: stall_o high in cycles 0..LAT, result valid in cycle LAT+1, next request accepted no earlier than cycle LAT+2.
- Word access:
  - address low 2 bits are forced to 0 (aligned);
  - little-endian: byte at A holds bits[7:0], byte at A+3 holds bits[31:24].
- Byte access:
  - read returns zero-extended {24'b0, mem[A]};
  - write stores wdata_i[7:0] at A only.
- Read: wb_data_o<=read data; rf_o<=load_c & rf_c.
- Write: RAM updated on the BUSY->DONE edge; wb_data_o unchanged; rf_o<=0.
- Address bits above ADDR_W are ignored (addresses wrap).
- Reset asserted mid-access: the access is abandoned and a pending write is not performed. After CLR rises, the FSM is in IDLE.
- A read issued in the cycle after a write DONE observes the written data.

Test Plan (LAT=2, ADDR_W=8):
- Word store then load: store enable=1 rw=1 size=0 addr=0x10 wdata=0xDEADBEEF, then load addr=0x10 with load=1 rf=1.
  - Store: stall_o high 3 cycles, rf_o=0.
  - Load: in DONE, wb_data_o=0xDEADBEEF and rf_o=1.
- Byte load after the word store, addr=0x11 -> wb_data_o=0x000000BE. Addr=0x113 (wraps to 0x13) -> 0x000000DE.
- Byte store wdata=0x12345655 at addr=0x12, then word load addr=0x13 (aligned to 0x10) -> 0xDE55BEEF.
- Pass-through: enable=0 alu_i=0xCAFE0001 rf=1 -> next cycle wb_data_o=0xCAFE0001, rf_o=1, stall_o never asserted. Back-to-back pass-through values appear one per cycle.
- Reset mid-op: assert CLR=0 during BUSY of a word store 0x11111111 to 0x20.
  - Outputs are immediately 0 and stall_o=0.
  - After release, a load from 0x20 does not return 0x11111111. Pre-load 0x20 with 0xAAAAAAAA; it reads back 0xAAAAAAAA.
- Held request: keep enable_i=1 constant across DONE. The access executes exactly once, IDLE re-accepts one cycle later, and stall_o pattern is 1,1,1,0,1,1,1,0.
